// File: rtl/pacman_pkg.sv
// Shared Pac-Man types and constants: power FSM states, score values, tile geometry.
package pacman_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        POWER = 2'd1,
        WARN  = 2'd2
    } power_state_t;

    localparam int EDOT_SCORE       = 50;
    localparam int GHOST_BASE_SCORE = 200;
    localparam int TILE_SHIFT       = 4;
    localparam int SCORE_W          = 12;

    // 200, 400, 800, 1600 for combo 0..3
    function automatic logic [SCORE_W-1:0] ghost_score(input logic [1:0] combo);
        return SCORE_W'(GHOST_BASE_SCORE) << combo;
    endfunction

endpackage

// File: rtl/edot_eat_controller_frame_timer.sv
// Frame down-counter for the frightened period: load, tick-decrement, zero detect.
module frame_timer #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         tick,
    output logic [W-1:0] count,
    output logic         zero
);

    // load wins over tick; the count holds at zero rather than wrapping
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= value;
        else if (tick && (count != '0))
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/edot_eat_controller.sv
// Energizer-dot eat controller: hit latch, one-frame removal window, power timer, scoring.
// Optional WARN (blink) phase is built only when EDOT_POWER_WARN_EN is defined.
module edot_eat_controller
    import pacman_pkg::*;
#(
    parameter int POWER_FRAMES = 360,
    parameter int WARN_FRAMES  = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] pixel_x,
    input  logic [10:0] pixel_y,
    input  logic        start_of_frame,
    input  logic        edots_dr,
    input  logic        pacman_dr,
    input  logic        ghost_eaten,
    input  logic        level_restart,
    output logic        remove_cur_edot,
    output logic        power_mode,
    output logic        ghosts_blink,
    output logic        score_valid,
    output logic [11:0] score_add
);

    // state | meaning
    // IDLE  | ghosts normal, ghost_eaten ignored
    // POWER | frightened, frames_left counting down
    // WARN  | frightened, trailing blink window (EDOT_POWER_WARN_EN only)

    localparam int FL_W = $clog2(POWER_FRAMES + 1);
    localparam logic [FL_W-1:0] FL_LOAD = FL_W'(POWER_FRAMES);
    localparam int TW = 11 - TILE_SHIFT;

    logic [TW-1:0]   tile_x, tile_y, tile_x_d, tile_y_d, lat_x, lat_y;
    logic            pending, armed, hit;
    logic [1:0]      combo, combo_eff;
    logic            ghost_ok, gp_valid;
    logic [11:0]     ghost_val, gp_val;
    power_state_t    state, state_nx;
    logic            tmr_load, fl_zero;
    logic [FL_W-1:0] tmr_value, frames_left;
    logic            unused_low_bits;

    assign tile_x = pixel_x[10:TILE_SHIFT];
    assign tile_y = pixel_y[10:TILE_SHIFT];
    assign unused_low_bits = ^{pixel_x[TILE_SHIFT-1:0], pixel_y[TILE_SHIFT-1:0]};

    assign hit = edots_dr && pacman_dr && !pending && !level_restart;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tile_x_d <= '0;
            tile_y_d <= '0;
            lat_x    <= '0;
            lat_y    <= '0;
            pending  <= 1'b0;
            armed    <= 1'b0;
        end else begin
            tile_x_d <= tile_x;
            tile_y_d <= tile_y;
            if (level_restart) begin
                pending <= 1'b0;
                armed   <= 1'b0;
            end else begin
                if (start_of_frame)
                    armed <= pending;
                if (hit) begin
                    pending <= 1'b1;
                    lat_x   <= tile_x_d;
                    lat_y   <= tile_y_d;
                end else if (start_of_frame) begin
                    pending <= 1'b0;
                end
            end
        end
    end

    assign remove_cur_edot = armed && (tile_x == lat_x) && (tile_y == lat_y);

    frame_timer #(.W(FL_W)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (tmr_load),
        .value (tmr_value),
        .tick  (start_of_frame),
        .count (frames_left),
        .zero  (fl_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        tmr_load  = 1'b0;
        tmr_value = FL_LOAD;
        if (level_restart) begin
            state_nx  = IDLE;
            tmr_load  = 1'b1;
            tmr_value = '0;
        end else if (hit) begin
            state_nx = POWER;
            tmr_load = 1'b1;
        end else begin
            case (state)
                IDLE: state_nx = IDLE;
`ifdef EDOT_POWER_WARN_EN
                POWER: begin
                    if (fl_zero)
                        state_nx = IDLE;
                    else if (frames_left == FL_W'(WARN_FRAMES))
                        state_nx = WARN;
                end
                WARN: if (fl_zero) state_nx = IDLE;
`else
                POWER: if (fl_zero) state_nx = IDLE;
`endif
                default: state_nx = IDLE;
            endcase
        end
    end

    assign power_mode = (state != IDLE);

`ifdef EDOT_POWER_WARN_EN
    localparam int BLINK_BIT = (FL_W > 3) ? 3 : FL_W - 1;
    assign ghosts_blink = (state == WARN) && frames_left[BLINK_BIT];
`else
    logic unused_warn;
    assign unused_warn  = ^{frames_left, FL_W'(WARN_FRAMES)};
    assign ghosts_blink = 1'b0;
`endif

    // a coincident hit restarts the chain before the ghost is scored
    assign ghost_ok  = ghost_eaten && power_mode && !level_restart;
    assign combo_eff = hit ? 2'd0 : combo;
    assign ghost_val = ghost_score(combo_eff);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            combo       <= 2'd0;
            gp_valid    <= 1'b0;
            gp_val      <= '0;
            score_valid <= 1'b0;
            score_add   <= '0;
        end else if (level_restart) begin
            combo       <= 2'd0;
            gp_valid    <= 1'b0;
            score_valid <= 1'b0;
            score_add   <= '0;
        end else begin
            if (ghost_ok)
                combo <= (combo_eff == 2'd3) ? 2'd3 : combo_eff + 2'd1;
            else if (hit)
                combo <= 2'd0;

            if (hit) begin
                score_valid <= 1'b1;
                score_add   <= 12'(EDOT_SCORE);
                gp_valid    <= ghost_ok;
                gp_val      <= ghost_val;
            end else if (gp_valid) begin
                score_valid <= 1'b1;
                score_add   <= gp_val;
                gp_valid    <= ghost_ok;
                gp_val      <= ghost_val;
            end else if (ghost_ok) begin
                score_valid <= 1'b1;
                score_add   <= ghost_val;
            end else begin
                score_valid <= 1'b0;
                score_add   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_edot_eat_controller.sv
// Bench for edot_eat_controller: two parameterisations against a behavioural model.
`timescale 1ns/1ps
module tb_edot_eat_controller;

    localparam int P0 = 10, W0 = 4, P1 = 20, W1 = 12;
`ifdef EDOT_POWER_WARN_EN
    localparam bit WARN_EN = 1'b1;
`else
    localparam bit WARN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [10:0] pixel_x = '0, pixel_y = '0;
    logic        start_of_frame = 1'b0, edots_dr = 1'b0, pacman_dr = 1'b0;
    logic        ghost_eaten = 1'b0, level_restart = 1'b0;
    logic [1:0]  rm, pm, gb, sv;
    logic [11:0] sa0, sa1;

    always #5 clk = ~clk;

    edot_eat_controller #(.POWER_FRAMES(P0), .WARN_FRAMES(W0)) u0 (
        .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .start_of_frame(start_of_frame), .edots_dr(edots_dr), .pacman_dr(pacman_dr),
        .ghost_eaten(ghost_eaten), .level_restart(level_restart),
        .remove_cur_edot(rm[0]), .power_mode(pm[0]), .ghosts_blink(gb[0]),
        .score_valid(sv[0]), .score_add(sa0));

    edot_eat_controller #(.POWER_FRAMES(P1), .WARN_FRAMES(W1)) u1 (
        .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .start_of_frame(start_of_frame), .edots_dr(edots_dr), .pacman_dr(pacman_dr),
        .ghost_eaten(ghost_eaten), .level_restart(level_restart),
        .remove_cur_edot(rm[1]), .power_mode(pm[1]), .ghosts_blink(gb[1]),
        .score_valid(sv[1]), .score_add(sa1));

    int n_total = 0, n_pass = 0, gb_ones = 0;

    task automatic check(input string name, input bit ok, input int act, input int exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    bit m_pend, m_arm;
    int m_lx, m_ly, m_tdx, m_tdy;
    int m_fl[2], m_combo[2], m_qn[2], m_sa[2];
    bit m_on[2], m_warn[2], m_sv[2];
    int m_q[2][4];

    function automatic int pf(input int i); return (i == 0) ? P0 : P1; endfunction
    function automatic int wf(input int i); return (i == 0) ? W0 : W1; endfunction

    task automatic model_clear();
        m_pend = 0; m_arm = 0; m_lx = 0; m_ly = 0; m_tdx = 0; m_tdy = 0;
        for (int i = 0; i < 2; i++) begin
            m_fl[i] = 0; m_combo[i] = 0; m_qn[i] = 0; m_sa[i] = 0;
            m_on[i] = 0; m_warn[i] = 0; m_sv[i] = 0;
        end
    endtask

    task automatic model_step();
        bit hit;
        int c;
        hit = edots_dr && pacman_dr && !m_pend && !level_restart;
        for (int i = 0; i < 2; i++) begin
            if (level_restart) begin
                m_fl[i] = 0; m_on[i] = 0; m_warn[i] = 0; m_combo[i] = 0;
                m_qn[i] = 0; m_sv[i] = 0; m_sa[i] = 0;
            end else begin
                if (hit) begin m_q[i][m_qn[i]] = 50; m_qn[i]++; end
                if (ghost_eaten && m_on[i]) begin
                    c = hit ? 0 : m_combo[i];
                    m_q[i][m_qn[i]] = 200 << c; m_qn[i]++;
                    m_combo[i] = (c < 3) ? c + 1 : 3;
                end else if (hit) begin
                    m_combo[i] = 0;
                end
                if (m_qn[i] > 0) begin
                    m_sv[i] = 1; m_sa[i] = m_q[i][0];
                    for (int k = 0; k < 3; k++) m_q[i][k] = m_q[i][k+1];
                    m_qn[i]--;
                end else begin
                    m_sv[i] = 0; m_sa[i] = 0;
                end
                if (hit) begin
                    m_on[i] = 1; m_warn[i] = 0; m_fl[i] = pf(i);
                end else begin
                    if (m_on[i]) begin
                        if (m_fl[i] == 0) begin m_on[i] = 0; m_warn[i] = 0; end
                        else if (WARN_EN && m_fl[i] == wf(i)) m_warn[i] = 1;
                    end
                    if (start_of_frame && m_fl[i] > 0) m_fl[i]--;
                end
            end
        end
        if (level_restart) begin
            m_pend = 0; m_arm = 0;
        end else begin
            if (start_of_frame) m_arm = m_pend;
            if (hit) begin m_pend = 1; m_lx = m_tdx; m_ly = m_tdy; end
            else if (start_of_frame) m_pend = 0;
        end
        m_tdx = int'(pixel_x >> 4);
        m_tdy = int'(pixel_y >> 4);
    endtask

    // compare on the falling edge, then advance the model with the inputs the DUT samples next
    initial begin
        int exp_v, act_v;
        bit e_rm;
        model_clear();
        forever begin
            @(negedge clk);
            if (reset) model_clear();
            e_rm = m_arm && (int'(pixel_x >> 4) == m_lx) && (int'(pixel_y >> 4) == m_ly);
            for (int i = 0; i < 2; i++) begin
                exp_v = {e_rm, m_on[i], m_warn[i] && m_fl[i][3], m_sv[i], m_sa[i][11:0]};
                act_v = {rm[i], pm[i], gb[i], sv[i], (i == 0) ? sa0 : sa1};
                check((i == 0) ? "outputs_u0" : "outputs_u1", act_v == exp_v, act_v, exp_v);
                if (gb[i]) gb_ones++;
            end
            if (!reset) model_step();
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
        start_of_frame = 0; edots_dr = 0; pacman_dr = 0;
        ghost_eaten = 0; level_restart = 0; reset = 0;
    endtask

    task automatic restart();
        step(); level_restart = 1;
        step();
    endtask

    task automatic do_hit(input int x, input int y);
        step(); pixel_x = 11'(x); pixel_y = 11'(y);
        step(); edots_dr = 1; pacman_dr = 1;
        step();
    endtask

    task automatic sof_pulse();
        step(); start_of_frame = 1;
        step();
    endtask

    task automatic px_check(input string name, input int x, input int y, input bit exp);
        step(); pixel_x = 11'(x); pixel_y = 11'(y);
        #1;
        check(name, rm[0] == exp, int'(rm[0]), int'(exp));
    endtask

    task automatic ghost_check(input string name, input int exp);
        step(); ghost_eaten = 1;
        step();
        check(name, sv[0] && sa0 == 12'(exp), sv[0] ? int'(sa0) : -1, exp);
    endtask

    initial begin
        int ghost_exp[5] = '{200, 400, 800, 1600, 1600};
        int rm_ones;
        #1 reset = 1;
        #2;
        check("reset_outputs", {rm, pm, gb, sv, sa0, sa1} == '0, int'({rm, pm, gb, sv}), 0);
        repeat (3) @(posedge clk);
        step();

        // hit at (100,52) -> tile (6,3), removal window in the following frame
        restart();
        do_hit(100, 52);
        check("edot_score", sv[0] && sa0 == 12'd50, sv[0] ? int'(sa0) : -1, 50);
        step();
        check("edot_score_once", sv[0] == 1'b0, int'(sv[0]), 0);
        px_check("rm_before_arm", 100, 52, 1'b0);
        sof_pulse();
        px_check("rm_96_48", 96, 48, 1'b1);
        px_check("rm_111_63", 111, 63, 1'b1);
        px_check("rm_95_50", 95, 50, 1'b0);
        px_check("rm_112_50", 112, 50, 1'b0);
        px_check("rm_100_47", 100, 47, 1'b0);
        px_check("rm_100_64", 100, 64, 1'b0);
        sof_pulse();
        px_check("rm_after_window", 100, 52, 1'b0);

        // frightened length and blink window
        restart();
        do_hit(200, 200);
        for (int k = 1; k <= 21; k++) begin
            sof_pulse();
            step();
            check("power_u0", pm[0] == (k < 10), int'(pm[0]), int'(k < 10));
            check("power_u1", pm[1] == (k < 20), int'(pm[1]), int'(k < 20));
            check("blink_u0", gb[0] == 1'b0, int'(gb[0]), 0);
            check("blink_u1", gb[1] == (WARN_EN && k >= 8 && k <= 12), int'(gb[1]),
                  int'(WARN_EN && k >= 8 && k <= 12));
        end

        // ghost combo chain saturates at 1600
        restart();
        do_hit(300, 300);
        for (int j = 0; j < 5; j++) ghost_check("ghost_chain", ghost_exp[j]);

        // ghost on the hit cycle: edot first, ghost one cycle later
        sof_pulse();
        sof_pulse();
        step(); pixel_x = 11'd40; pixel_y = 11'd40;
        step(); edots_dr = 1; pacman_dr = 1; ghost_eaten = 1;
        step();
        check("coincide_edot", sv[0] && sa0 == 12'd50, sv[0] ? int'(sa0) : -1, 50);
        step();
        check("coincide_ghost", sv[0] && sa0 == 12'd200, sv[0] ? int'(sa0) : -1, 200);

        // second hit at frame 5 reloads the timer and the combo
        restart();
        do_hit(500, 100);
        for (int k = 0; k < 4; k++) sof_pulse();
        ghost_check("reload_ghost_pre", 200);
        do_hit(520, 100);
        check("reload_edot", sv[0] && sa0 == 12'd50, sv[0] ? int'(sa0) : -1, 50);
        ghost_check("reload_ghost_post", 200);
        for (int k = 1; k <= 10; k++) begin
            sof_pulse();
            step();
            check("reload_power", pm[0] == (k < 10), int'(pm[0]), int'(k < 10));
        end

        // reset while armed discards the removal
        restart();
        do_hit(100, 52);
        sof_pulse();
        px_check("armed_before_reset", 100, 52, 1'b1);
        step(); reset = 1;
        step();
        rm_ones = 0;
        for (int j = 0; j < 16; j++) begin
            step(); pixel_x = 11'(96 + j); pixel_y = 11'd52;
            #1;
            if (rm[0]) rm_ones++;
        end
        check("rm_after_reset", rm_ones == 0, rm_ones, 0);

        // randomized traffic, biased toward the latched tile
        for (int n = 0; n < 6000; n++) begin
            step();
            if ($urandom_range(0, 1) == 1) begin
                pixel_x = 11'((((m_lx + int'($urandom_range(0, 2)) + 127) & 127) * 16) + int'($urandom_range(0, 15)));
                pixel_y = 11'((((m_ly + int'($urandom_range(0, 2)) + 127) & 127) * 16) + int'($urandom_range(0, 15)));
            end else begin
                pixel_x = 11'($urandom_range(0, 2047));
                pixel_y = 11'($urandom_range(0, 2047));
            end
            start_of_frame = ($urandom_range(0, 15) == 0);
            edots_dr       = ($urandom_range(0, 3) == 0);
            pacman_dr      = ($urandom_range(0, 149) == 0);
            ghost_eaten    = ($urandom_range(0, 19) == 0);
            level_restart  = ($urandom_range(0, 799) == 0);
            reset          = ($urandom_range(0, 1999) == 0);
        end
        step();

`ifdef EDOT_POWER_WARN_EN
        check("blink_seen", gb_ones > 0, gb_ones, 1);
`else
        check("blink_never", gb_ones == 0, gb_ones, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
